// File: rtl/axi_tdd_ng_stream_gate_if.sv
// Sample-in / packet-out stream bundle for the TDD stream gate.
// The gate holds the master modport. The environment holds the slave modport.
`timescale 1ns/1ps
interface axi_tdd_ng_stream_gate_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  s_axis_valid;
    logic [DATA_WIDTH-1:0] s_axis_data;
    logic                  m_axis_valid;
    logic                  m_axis_ready;
    logic [DATA_WIDTH-1:0] m_axis_data;
    logic                  m_axis_last;
    logic                  m_axis_user;

    modport master (
        input  s_axis_valid, s_axis_data, m_axis_ready,
        output m_axis_valid, m_axis_data, m_axis_last, m_axis_user
    );

    modport slave (
        output s_axis_valid, s_axis_data, m_axis_ready,
        input  m_axis_valid, m_axis_data, m_axis_last, m_axis_user
    );
endinterface

// File: rtl/axi_tdd_ng_stream_gate.sv
// Cuts one AXI-Stream packet per high window of a TDD channel from a non-stallable sample stream.
// A one-beat hold register (P) defers each beat until it is known whether that beat is the last one.
`timescale 1ns/1ps
module axi_tdd_ng_stream_gate #(
    parameter int DATA_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int LIMIT_WIDTH  = 16,
    parameter int STATUS_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tdd_gate,
    input  logic                    cfg_enable,
    input  logic [LIMIT_WIDTH-1:0]  cfg_beat_limit,
    axi_tdd_ng_stream_gate_if.master axis,
    output logic                    active,
    output logic [STATUS_WIDTH-1:0] window_count,
    output logic [STATUS_WIDTH-1:0] drop_count,
    output logic                    window_missed
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, OPEN, LIMITED, CLOSING} state_e;

    state_e                  state_q, state_d;
    logic                    gate_q;
    logic [DATA_WIDTH-1:0]   pData_q, pData_d;
    logic                    pUser_q, pUser_d, pFull_q, pFull_d;
    logic                    first_q, first_d;
    logic [LIMIT_WIDTH-1:0]  beatCnt_q, beatCnt_d;
    logic [STATUS_WIDTH-1:0] windowCnt_q, windowCnt_d, dropCnt_q, dropCnt_d;
    logic                    missed_q, missed_d;

    logic                    rise, fall, closeReq, limitHit, canPush, acceptBeat, winDone, drop;
    logic                    push, pushLast, pushUser;
    logic [DATA_WIDTH-1:0]   pushData;
    logic [LIMIT_WIDTH-1:0]  cntInc;

    logic [DATA_WIDTH+1:0]   mem [FIFO_DEPTH];
    logic [AW:0]             wrPtr_q, rdPtr_q;
    logic [DATA_WIDTH+1:0]   rdEntry;
    logic                    fifoEmpty, fifoFull, popping;

    assign rise      = tdd_gate & ~gate_q;
    assign fall      = ~tdd_gate & gate_q;
    assign closeReq  = fall | ~cfg_enable;
    assign cntInc    = beatCnt_q + LIMIT_WIDTH'(1);
    assign limitHit  = (cfg_beat_limit != '0) && (cntInc == cfg_beat_limit);

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign popping   = ~fifoEmpty & axis.m_axis_ready;
    assign canPush   = ~fifoFull | popping;
    assign rdEntry   = mem[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rise && cfg_enable) state_d = OPEN;
            OPEN: begin
                if (closeReq)                    state_d = winDone ? IDLE : CLOSING;
                else if (acceptBeat && limitHit) state_d = LIMITED;
            end
            LIMITED: if (fall)    state_d = winDone ? IDLE : CLOSING;
            CLOSING: if (winDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final push of P is only withheld when the FIFO is full. It is never dropped.
    always_comb begin
        pData_d    = pData_q;
        pUser_d    = pUser_q;
        pFull_d    = pFull_q;
        first_d    = first_q;
        beatCnt_d  = beatCnt_q;
        push       = 1'b0;
        pushData   = pData_q;
        pushLast   = 1'b0;
        pushUser   = pUser_q;
        acceptBeat = 1'b0;
        winDone    = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise && cfg_enable) begin
                    beatCnt_d = '0;
                    first_d   = 1'b1;
                    pFull_d   = 1'b0;
                end
            end
            OPEN: begin
                if (closeReq) begin
                    if (pFull_q) begin
                        pushLast = 1'b1;
                        if (canPush) begin
                            push    = 1'b1;
                            pFull_d = 1'b0;
                            winDone = 1'b1;
                        end
                    end else begin
                        winDone = 1'b1;
                    end
                end else if (axis.s_axis_valid) begin
                    if (!canPush && (pFull_q || limitHit)) begin
                        drop = 1'b1;
                    end else begin
                        acceptBeat = 1'b1;
                        beatCnt_d  = cntInc;
                        first_d    = 1'b0;
                        if (pFull_q) begin
                            push = 1'b1;
                        end else if (limitHit) begin
                            push     = 1'b1;
                            pushData = axis.s_axis_data;
                            pushLast = 1'b1;
                            pushUser = first_q;
                        end
                        if (pFull_q || !limitHit) begin
                            pData_d = axis.s_axis_data;
                            pUser_d = first_q;
                            pFull_d = 1'b1;
                        end
                    end
                end
            end
            LIMITED: begin
                if (pFull_q) begin
                    pushLast = 1'b1;
                    if (canPush) begin
                        push    = 1'b1;
                        pFull_d = 1'b0;
                    end
                end
                if (fall && (!pFull_q || canPush)) winDone = 1'b1;
            end
            CLOSING: begin
                pushLast = 1'b1;
                if (canPush) begin
                    push    = 1'b1;
                    pFull_d = 1'b0;
                    winDone = 1'b1;
                end
            end
            default: ;
        endcase
        windowCnt_d = winDone ? windowCnt_q + STATUS_WIDTH'(1) : windowCnt_q;
        dropCnt_d   = (drop && dropCnt_q != '1) ? dropCnt_q + STATUS_WIDTH'(1) : dropCnt_q;
        missed_d    = missed_q | (rise && state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q      <= 1'b0;
            pData_q     <= '0;
            pUser_q     <= 1'b0;
            pFull_q     <= 1'b0;
            first_q     <= 1'b0;
            beatCnt_q   <= '0;
            windowCnt_q <= '0;
            dropCnt_q   <= '0;
            missed_q    <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
        end else begin
            gate_q      <= tdd_gate;
            pData_q     <= pData_d;
            pUser_q     <= pUser_d;
            pFull_q     <= pFull_d;
            first_q     <= first_d;
            beatCnt_q   <= beatCnt_d;
            windowCnt_q <= windowCnt_d;
            dropCnt_q   <= dropCnt_d;
            missed_q    <= missed_d;
            if (push)    wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (popping) rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr_q[AW-1:0]] <= {pushUser, pushLast, pushData};
    end

    // Payload is masked while empty so that the outputs read zero from reset onward.
    assign axis.m_axis_valid = ~fifoEmpty;
    assign axis.m_axis_data  = fifoEmpty ? '0 : rdEntry[DATA_WIDTH-1:0];
    assign axis.m_axis_last  = ~fifoEmpty & rdEntry[DATA_WIDTH];
    assign axis.m_axis_user  = ~fifoEmpty & rdEntry[DATA_WIDTH+1];

    assign active        = (state_q != IDLE);
    assign window_count  = windowCnt_q;
    assign drop_count    = dropCnt_q;
    assign window_missed = missed_q;
endmodule
